// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   Decode-to-execute pipeline register placed directly after the 8x8 register
//   file. Captures Read1/Read2 data, the immediate and the control fields into
//   the ID/EX register, and hosts the load-use hazard detector. A load whose
//   result is still pending in EX forces one bubble into EX and stalls IF/ID
//   for that cycle. A branch flush kills the ID instruction, and a downstream
//   hold freezes the whole ID/EX register.
//
// Optional feature (compile-time macro BUBBLE_COUNT_EN):
//   When defined, adds output bubble_count[15:0], a saturating count of the
//   hazard bubbles inserted since reset.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   id_valid              IF/ID holds a real instruction
//   id_rs1/id_rs2         source registers (also drive register file reads)
//   id_use_rs1/id_use_rs2 instruction actually reads rs1/rs2
//   id_rd                 destination register
//   id_rdata1/id_rdata2   register file read data
//   id_imm, id_alu_op     decoded immediate and ALU operation
//   id_reg_write/id_mem_read/id_mem_write  decoded control
//   flush                 branch taken in EX: kill the ID instruction
//   ex_hold               downstream not accepting: freeze ID/EX
//   stall_id              hold PC and IF/ID this cycle (combinational)
//   bubble_count          hazard bubble counter (BUBBLE_COUNT_EN only)
//   ex_*                  registered ID/EX contents; control is 0 when !ex_valid
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DATA_W  = 8,
    parameter int REG_AW  = 3,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [REG_AW-1:0]  id_rs1,
    input  logic [REG_AW-1:0]  id_rs2,
    input  logic               id_use_rs1,
    input  logic               id_use_rs2,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic [DATA_W-1:0]  id_rdata1,
    input  logic [DATA_W-1:0]  id_rdata2,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               flush,
    input  logic               ex_hold,
    output logic               stall_id,
`ifdef BUBBLE_COUNT_EN
    output logic [15:0]        bubble_count,
`endif
    output logic               ex_valid,
    output logic [REG_AW-1:0]  ex_rs1,
    output logic [REG_AW-1:0]  ex_rs2,
    output logic [REG_AW-1:0]  ex_rd,
    output logic [DATA_W-1:0]  ex_rdata1,
    output logic [DATA_W-1:0]  ex_rdata2,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write
);

    typedef struct packed {
        logic               valid;
        logic [REG_AW-1:0]  rs1;
        logic [REG_AW-1:0]  rs2;
        logic [REG_AW-1:0]  rd;
        logic [DATA_W-1:0]  rdata1;
        logic [DATA_W-1:0]  rdata2;
        logic [DATA_W-1:0]  imm;
        logic [ALUOP_W-1:0] alu_op;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
    } idex_t;

    idex_t ex_r;
    idex_t load_s;
    logic  rs1_match_s;
    logic  rs2_match_s;
    logic  hazard_s;
    logic  bubble_s;

    // Load-use detection against the instruction currently held in EX.
    // A load to register 0 never matters because register 0 reads as zero.
    always_comb begin
        rs1_match_s = id_use_rs1 & (id_rs1 == ex_r.rd);
        rs2_match_s = id_use_rs2 & (id_rs2 == ex_r.rd);
        hazard_s    = ex_r.valid & ex_r.mem_read & ex_r.reg_write &
                      (ex_r.rd != {REG_AW{1'b0}}) & id_valid &
                      (rs1_match_s | rs2_match_s);
        // A flush discards the ID instruction, so there is nothing to stall for.
        stall_id    = (hazard_s | ex_hold) & ~flush;
        // A bubble is only really inserted when neither flush nor hold wins.
        bubble_s    = hazard_s & ~flush & ~ex_hold;
    end

    // Next ID/EX contents for a normal advance; control is qualified by id_valid.
    always_comb begin
        load_s.valid     = id_valid;
        load_s.rs1       = id_rs1;
        load_s.rs2       = id_rs2;
        load_s.rd        = id_rd;
        load_s.rdata1    = id_rdata1;
        load_s.rdata2    = id_rdata2;
        load_s.imm       = id_imm;
        load_s.alu_op    = id_alu_op;
        load_s.reg_write = id_reg_write & id_valid;
        load_s.mem_read  = id_mem_read  & id_valid;
        load_s.mem_write = id_mem_write & id_valid;
    end

    // ID/EX register: flush beats hold, hold beats bubble, bubble beats advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_r <= '0;
        end else if (flush) begin
            ex_r <= '0;
        end else if (ex_hold) begin
            ex_r <= ex_r;
        end else if (hazard_s) begin
            // Bubble: an empty slot, all fields cleared.
            ex_r <= '0;
        end else begin
            ex_r <= load_s;
        end
    end

`ifdef BUBBLE_COUNT_EN
    logic [15:0] bubble_count_r;

    // Saturating count of inserted load-use bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_count_r <= 16'd0;
        end else if (bubble_s && (bubble_count_r != 16'hFFFF)) begin
            bubble_count_r <= bubble_count_r + 16'd1;
        end else begin
            bubble_count_r <= bubble_count_r;
        end
    end

    assign bubble_count = bubble_count_r;
`endif

    assign ex_valid     = ex_r.valid;
    assign ex_rs1       = ex_r.rs1;
    assign ex_rs2       = ex_r.rs2;
    assign ex_rd        = ex_r.rd;
    assign ex_rdata1    = ex_r.rdata1;
    assign ex_rdata2    = ex_r.rdata2;
    assign ex_imm       = ex_r.imm;
    assign ex_alu_op    = ex_r.alu_op;
    assign ex_reg_write = ex_r.reg_write;
    assign ex_mem_read  = ex_r.mem_read;
    assign ex_mem_write = ex_r.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//   Directed-vector bench for id_ex_stage. A behavioural model tracks what the
//   EX slot must contain; a compare process checks the DUT against it on every
//   falling edge. Hand-computed literal checks pin the model itself.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_use_rs1, id_use_rs2;
    logic [2:0] id_rs1, id_rs2, id_rd;
    logic [7:0] id_rdata1, id_rdata2, id_imm;
    logic [3:0] id_alu_op;
    logic       id_reg_write, id_mem_read, id_mem_write;
    logic       flush, ex_hold;
    logic       stall_id, ex_valid;
    logic [2:0] ex_rs1, ex_rs2, ex_rd;
    logic [7:0] ex_rdata1, ex_rdata2, ex_imm;
    logic [3:0] ex_alu_op;
    logic       ex_reg_write, ex_mem_read, ex_mem_write;
`ifdef BUBBLE_COUNT_EN
    logic [15:0] bubble_count;
`endif

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush), .ex_hold(ex_hold), .stall_id(stall_id),
`ifdef BUBBLE_COUNT_EN
        .bubble_count(bubble_count),
`endif
        .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
        .ex_alu_op(ex_alu_op), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
    );

    // ---------------- behavioural model ----------------
    // m_* describe the instruction sitting in EX (m_v=0 means empty slot).
    logic       m_v, m_rw, m_mr, m_mw;
    logic [2:0] m_rs1, m_rs2, m_rd;
    logic [7:0] m_d1, m_d2, m_imm;
    logic [3:0] m_op;
    int         m_bubbles;

    function automatic logic m_hazard();
        if (!(m_v && m_mr && m_rw && m_rd != 3'd0 && id_valid)) return 1'b0;
        return (id_use_rs1 && id_rs1 == m_rd) || (id_use_rs2 && id_rs2 == m_rd);
    endfunction

    function automatic logic m_stall();
        return (m_hazard() || ex_hold) && !flush;
    endfunction

    // Model advance: what the EX slot becomes after each rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush || (!ex_hold && m_hazard())) begin
            if (rst_n && !flush) m_bubbles <= m_bubbles + 1;
            if (!rst_n) m_bubbles <= 0;
            m_v <= 1'b0; m_rw <= 1'b0; m_mr <= 1'b0; m_mw <= 1'b0;
            m_rs1 <= 3'd0; m_rs2 <= 3'd0; m_rd <= 3'd0;
            m_d1 <= 8'd0; m_d2 <= 8'd0; m_imm <= 8'd0; m_op <= 4'd0;
        end else if (!ex_hold) begin
            m_v  <= id_valid;
            m_rw <= id_reg_write && id_valid;
            m_mr <= id_mem_read && id_valid;
            m_mw <= id_mem_write && id_valid;
            m_rs1 <= id_rs1; m_rs2 <= id_rs2; m_rd <= id_rd;
            m_d1 <= id_rdata1; m_d2 <= id_rdata2; m_imm <= id_imm; m_op <= id_alu_op;
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Compare process: DUT against model on every falling edge.
    always @(negedge clk) begin
        chk("stall_id",  {15'd0, stall_id},     {15'd0, m_stall()});
        chk("ex_valid",  {15'd0, ex_valid},     {15'd0, m_v});
        chk("ex_ctrl",   {13'd0, ex_reg_write, ex_mem_read, ex_mem_write},
                         {13'd0, m_rw, m_mr, m_mw});
        if (m_v) begin
            chk("ex_regs", {7'd0, ex_rs1, ex_rs2, ex_rd}, {7'd0, m_rs1, m_rs2, m_rd});
            chk("ex_data", {ex_rdata1, ex_rdata2}, {m_d1, m_d2});
            chk("ex_imm_op", {4'd0, ex_imm, ex_alu_op}, {4'd0, m_imm, m_op});
        end
`ifdef BUBBLE_COUNT_EN
        chk("bubble_count", bubble_count, m_bubbles[15:0]);
`endif
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_id(input logic v, input logic [2:0] rs1, input logic [2:0] rs2,
                          input logic u1, input logic u2, input logic [2:0] rd,
                          input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] imm,
                          input logic [3:0] op, input logic rw, input logic mr, input logic mw);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_rdata1 = d1; id_rdata2 = d2; id_imm = imm; id_alu_op = op;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; ex_hold = 1'b0;
        set_id(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        chk("reset_valid", {15'd0, ex_valid}, 16'd0);
        chk("reset_stall", {15'd0, stall_id}, 16'd0);
        rst_n = 1'b1;

        // Pass-through.
        set_id(1'b1, 3'd1, 3'd5, 1'b1, 1'b1, 3'd3, 8'h5A, 8'hC3, 8'h11, 4'd2, 1'b1, 1'b0, 1'b0);
        tick();
        chk("pass_rd",    {13'd0, ex_rd}, 16'd3);
        chk("pass_data",  {ex_rdata1, ex_rdata2}, 16'h5AC3);
        chk("pass_op",    {12'd0, ex_alu_op}, 16'd2);
        chk("pass_valid", {15'd0, ex_valid}, 16'd1);

        // Load-use: load r2 then a reader of r2.
        set_id(1'b1, 3'd1, 3'd1, 1'b1, 1'b0, 3'd2, 8'h40, 8'h00, 8'h04, 4'd0, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 3'd5, 8'h77, 8'h00, 8'h00, 4'd1, 1'b1, 1'b0, 1'b0);
        #1 chk("lu_stall", {15'd0, stall_id}, 16'd1);
        tick();
        chk("lu_bubble", {15'd0, ex_valid}, 16'd0);
        chk("lu_nostall", {15'd0, stall_id}, 16'd0);
`ifdef BUBBLE_COUNT_EN
        chk("lu_count", bubble_count, 16'd1);
`endif
        tick();
        chk("lu_issue", {7'd0, ex_valid, ex_rd, ex_rdata1}, {7'd0, 1'b1, 3'd5, 8'h77});

        // No false hazard: load to r0, then reader of r0.
        set_id(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 4'd0, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 3'd0, 3'd3, 1'b1, 1'b0, 3'd4, 8'h00, 8'h00, 8'h08, 4'd0, 1'b1, 1'b1, 1'b0);
        #1 chk("r0_nostall", {15'd0, stall_id}, 16'd0);
        tick();
        chk("r0_issue", {12'd0, ex_valid, ex_rd}, {12'd0, 1'b1, 3'd4});
        // Load r4 in EX; ID names r4 as rs2 but does not read it.
        set_id(1'b1, 3'd1, 3'd4, 1'b1, 1'b0, 3'd6, 8'h12, 8'h34, 8'h00, 4'd3, 1'b1, 1'b0, 1'b0);
        #1 chk("nouse_nostall", {15'd0, stall_id}, 16'd0);
        tick();
        chk("nouse_issue", {12'd0, ex_valid, ex_rd}, {12'd0, 1'b1, 3'd6});

        // Flush beats hazard.
        set_id(1'b1, 3'd1, 3'd1, 1'b1, 1'b0, 3'd2, 8'h00, 8'h00, 8'h00, 4'd0, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 3'd7, 8'h99, 8'h00, 8'h00, 4'd1, 1'b1, 1'b0, 1'b0);
        flush = 1'b1;
        #1 chk("flush_stall", {15'd0, stall_id}, 16'd0);
        tick();
        flush = 1'b0;
        chk("flush_out", {7'd0, ex_valid, ex_reg_write, ex_rdata1}, 16'd0);
`ifdef BUBBLE_COUNT_EN
        chk("flush_count", bubble_count, 16'd1);
`endif

        // Hold for three cycles while ID keeps changing.
        set_id(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 3'd1, 8'hA1, 8'h01, 8'h00, 4'd5, 1'b1, 1'b0, 1'b0);
        tick();
        ex_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 3'd3, 3'd4, 1'b1, 1'b1, 3'd6, 8'hB0 + 8'(i), 8'h02, 8'h00, 4'd6, 1'b0, 1'b0, 1'b1);
            #1 chk("hold_stall", {15'd0, stall_id}, 16'd1);
            tick();
            chk("hold_keep", {5'd0, ex_rd, ex_rdata1}, {5'd0, 3'd1, 8'hA1});
        end
        ex_hold = 1'b0;
        set_id(1'b1, 3'd3, 3'd4, 1'b1, 1'b1, 3'd6, 8'hC6, 8'h02, 8'h00, 4'd6, 1'b0, 1'b0, 1'b1);
        tick();
        chk("hold_release", {5'd0, ex_rd, ex_rdata1}, {5'd0, 3'd6, 8'hC6});

        // Reset mid-stall.
        set_id(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd3, 8'h00, 8'h00, 8'h00, 4'd0, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 3'd1, 3'd3, 1'b0, 1'b1, 3'd5, 8'h3C, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
        #1 chk("pre_rst_stall", {15'd0, stall_id}, 16'd1);
        rst_n = 1'b0;
        #1 chk("rst_async", {6'd0, ex_valid, stall_id, ex_rdata1}, 16'd0);
        chk("rst_ctrl", {10'd0, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write}, 16'd0);
`ifdef BUBBLE_COUNT_EN
        chk("rst_count", bubble_count, 16'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        chk("restart", {7'd0, ex_valid, ex_rdata1}, {7'd0, 1'b1, 8'h3C});
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
